// File: rtl/riscv_mem_responder.sv
// Unified word memory for the multicycle core: one request, LATENCY wait states, one-cycle ready.
// Define MEM_ALIGN_CHECK_EN to fault on byte addresses with addr[1:0] != 0.
module riscv_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        error,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT =
    ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              cap_wr;
  logic              cap_fault;
  logic [ADDR_W-1:0] cap_idx;
  logic [31:0]       cap_wdata;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              both;
  logic              range_bad;
  logic              align_bad;
  logic              in_fault;
  logic              go_resp;
  logic              req_wr;
  logic              req_fault;
  logic [ADDR_W-1:0] req_idx;
  logic [31:0]       req_wdata;

  assign accept    = (state == IDLE) &&
                     (mem_read || mem_write);
  assign both      = mem_read && mem_write;
  assign range_bad = (addr >> (ADDR_W + 2)) != 32'd0;

`ifdef MEM_ALIGN_CHECK_EN
  assign align_bad = addr[1:0] != 2'b00;
`else
  logic unused_lsb;
  assign align_bad  = 1'b0;
  assign unused_lsb = ^addr[1:0];
`endif

  assign in_fault = both || range_bad || align_bad;

  // with zero latency the commit edge is the accept edge,
  // so the live request must be used instead of the captures
  assign go_resp = (ZERO_LAT && accept) ||
                   (state == WAIT && cnt == 4'd0);

  always_comb begin
    req_wr    = cap_wr;
    req_fault = cap_fault;
    req_idx   = cap_idx;
    req_wdata = cap_wdata;
    if (state == IDLE) begin
      req_wr    = mem_write;
      req_fault = in_fault;
      req_idx   = addr[ADDR_W+1:2];
      req_wdata = wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_wr    <= 1'b0;
      cap_fault <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= 32'd0;
      rdata     <= 32'd0;
      ready     <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ready <= go_resp;
      error <= go_resp && req_fault;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cap_wr    <= mem_write;
            cap_fault <= in_fault;
            cap_idx   <= addr[ADDR_W+1:2];
            cap_wdata <= wdata;
            busy      <= 1'b1;
            cnt       <= CNT_INIT;
            state     <= ZERO_LAT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (go_resp) begin
        if (!req_wr && !req_fault) begin
          rdata <= mem[req_idx];
        end else begin
          rdata <= 32'd0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && go_resp && req_wr && !req_fault) begin
      mem[req_idx] <= req_wdata;
    end
  end

endmodule

// File: doc/riscv_mem_responder.md
# riscv_mem_responder

Word-addressed unified memory responder serving the multicycle RISC-V core's instruction-fetch, load and store requests. It accepts one read or write request, inserts a fixed number of wait states, then returns a single-cycle `ready` pulse with read data or write completion. It sits on the datapath's memory port, driven by the core's MemRead/MemWrite/address/write-data signals.

## Interface
- `ADDR_W`, 10: word-address width; memory depth is 2**ADDR_W 32-bit words.
- `LATENCY`, 2: wait-state cycles between acceptance and response (0–15).
- `clock`  in  1  single clock; all state updates on the positive edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  read request, sampled in IDLE.
- `mem_write`  in  1  write request, sampled in IDLE.
- `addr`  in  32  byte address; word index is `addr[ADDR_W+1:2]`.
- `wdata`  in  32  store data, sampled with the request.
- `rdata`  out  32  read data; valid while `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `error`  out  1  asserted with `ready` when the request faulted.
- `busy`  out  1  high in WAIT and RESP; requests are ignored while high.

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: if `mem_read` xor `mem_write` is 1, capture op, `addr`, `wdata`; go to WAIT (or RESP if `LATENCY`=0). If both are 1, capture as a faulted request (error path, no write). If neither is 1, stay in IDLE.
- WAIT: the down-counter is loaded with `LATENCY`-1 on accept and decrements each cycle. Go to RESP when it reaches 0.
- RESP: `ready`=1 for exactly one cycle, then unconditionally go to IDLE.
- Fault conditions:
  - out-of-range address: `addr[31:ADDR_W+2]` ≠ 0;
  - both request lines high;
  - misaligned address when the check is compiled in.
- On a fault: `error`=1 in RESP, `rdata`=0, and memory is unmodified.
- Write commit: the array is written on the edge entering RESP, only when the request is a good write.
- Read: `rdata` is registered on the edge entering RESP from the captured address. It holds its value until the next read response; write and fault responses drive it to 0.
- Request lines and `addr`/`wdata` changing after acceptance have no effect.
- A request still held high in the cycle after RESP is accepted as a new request. The requester deasserts on seeing `ready`.

## Timing
- Reset values: `rdata`=0, `ready`=0, `error`=0, `busy`=0; counter=0; captured registers=0.
- The memory array is not reset; its contents survive reset.
- Latency from accepting edge to `ready` high is `LATENCY`+1 cycles; `LATENCY`=0 gives `ready` in the cycle after accept.
- Throughput: one request per `LATENCY`+2 cycles (IDLE, WAIT×`LATENCY`, RESP).
- Reset mid-operation:
  - returns immediately to IDLE with all outputs at reset values;
  - a pending write is discarded if reset precedes the commit edge.
- `ready`, `error` and `busy` are registered state decodes with no combinational path from inputs.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: `addr[1:0]` ≠ 0 is a fault (`error`=1, no write, `rdata`=0).
- Undefined: `addr[1:0]` is ignored and the access uses the word index only.

## Test plan
- Reset, then write 0xDEADBEEF to addr 0x10 with `LATENCY`=2 → `ready` pulses 3 cycles after accept with `error`=0. A subsequent read of 0x10 returns `rdata`=0xDEADBEEF with `ready`.
- Read of addr 0x1000 with `ADDR_W`=10 → `error`=1 and `rdata`=0 with `ready`; a follow-up read of 0x0 shows memory unchanged.
- `mem_read`=`mem_write`=1 at addr 0x20 with `wdata`=0x12345678 → `error`=1; a later read of 0x20 returns its prior value.
- With `MEM_ALIGN_CHECK_EN`, write to 0x22 → `error`=1. Without the macro, the same write stores to word 8, and a read of 0x20 returns the stored data.
- Assert `reset_n`=0 in the WAIT cycle of a write of 0xCAFEF00D to 0x30 → outputs return to 0 at once and `busy`=0; a subsequent read of 0x30 does not return 0xCAFEF00D.
- `LATENCY`=0 with back-to-back reads held high → `ready` every 2nd cycle and `busy` toggling 0/1; changing `addr` during RESP does not alter the data returned.
